mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  Memory-side bus slave for the extended DLX. Directly downstream of the master's
//  memory-access state machine: consumes AS_N/WR_N/address/data and returns ACK_N and read data.
//  Holds an internal word-addressed RAM and models a fixed number of wait states,
//  so master stall (busy/STOP_N) behaviour is exercised with realistic latency.
// PARAMETERS
//  ADDR_W       8   word address width; RAM depth = 2**ADDR_W words
//  DATA_W       32  data word width
//  WAIT_STATES  2   cycles between request capture and ACK; legal range 0..15
// PORTS
//  CLK      in   1       clock, all logic on rising edge
//  RESET    in   1       synchronous, active-high reset
//  AS_N     in   1       address strobe from master, active low
//  WR_N     in   1       0 = write, 1 = read; sampled together with AS_N
//  ADDR     in   ADDR_W  word address; sampled with AS_N
//  DIN      in   DATA_W  write data; sampled with AS_N
//  ACK_N    out  1       transfer acknowledge to master, active low, registered
//  DOUT     out  DATA_W  read data, registered
//  STATE    out  2       current FSM state (debug/verification)
//  TXN_CNT  out  16      completed-transfer counter
// BEHAVIOUR
//  Reset (RESET=1 at an edge): state=IDLE, ACK_N=1, DOUT=0, TXN_CNT=0, counter=0,
//   no RAM write at that edge. RAM contents are not cleared. RESET wins over all events.
//  FSM states / encoding: IDLE=0, COUNT=1, ACK=2, RELEASE=3. Transitions on rising edge:
//   IDLE:    AS_N=0 -> latch ADDR, WR_N, DIN; WAIT_STATES=0 -> ACK, else cnt<=WAIT_STATES -> COUNT.
//            AS_N=1 -> stay.
//   COUNT:   AS_N=1 -> abort to IDLE (no write, no ack, TXN_CNT unchanged).
//            cnt==1 -> ACK; else cnt<=cnt-1, stay.
//   ACK:     unconditionally -> RELEASE (ACK_N low for exactly one cycle).
//   RELEASE: AS_N=1 -> IDLE; AS_N=0 -> stay (no new request accepted until strobe drops).
//  ACK_N = 0 only while state==ACK; registered, glitch-free.
//  Latency: AS_N sampled low at edge k -> ACK_N low from edge k+WAIT_STATES to k+WAIT_STATES+1.
//  Memory access occurs at the edge entering ACK, using the latched address/data:
//   latched write (WR_N=0): RAM[addr] <= din; DOUT unchanged.
//   latched read  (WR_N=1): DOUT <= RAM[addr]; valid while ACK_N=0 and held until the next read.
//  ADDR/DIN/WR_N changes after capture are ignored until the next IDLE capture.
//  TXN_CNT increments by 1 at the edge entering ACK; 16-bit wrap 0xFFFF -> 0x0000.
//  Back-to-back: request seen in RELEASE while AS_N still low is not re-accepted; the master
//   must deassert AS_N (its NEXT state) for at least one edge before the next capture.
//  Read-after-write to the same address returns the newly written word.
//  X/Z on AS_N is not handled; the bench must drive clean levels.
// TESTING
//  1 Reset: RESET=1 two cycles with AS_N=0 -> ACK_N=1, DOUT=0, STATE=0, TXN_CNT=0, no RAM write.
//  2 Write then read, WAIT_STATES=2: write 0xDEADBEEF @0x10, read @0x10 -> ACK_N low 2 cycles
//    after each capture edge, for one cycle; DOUT=0xDEADBEEF during read ACK; TXN_CNT=2.
//  3 WAIT_STATES=0: read @0x05 preloaded 0x12345678 -> ACK_N low in the cycle right after
//    the capture edge, DOUT=0x12345678.
//  4 Abort: AS_N low 1 cycle then high while in COUNT (WAIT_STATES=3), write 0xAAAA @0x20
//    -> back to IDLE, no ACK, RAM[0x20] and TXN_CNT unchanged.
//  5 Strobe held low after ACK: AS_N kept low 3 extra cycles -> STATE stays RELEASE, single
//    ACK pulse only; AS_N high then low -> new transfer accepted normally.
//  6 Closed loop with the master FSM: 8 alternating MW/MR transfers -> master busy
//    deasserts exactly once per transfer, data matches a reference model, TXN_CNT=8.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side bus slave for the extended DLX: word-addressed RAM behind an AS_N/ACK_N
// handshake with a fixed number of wait states before each acknowledge.
module mem_bus_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AS_N,
    input  logic              WR_N,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic              ACK_N,
    output logic [DATA_W-1:0] DOUT,
    output logic [1:0]        STATE,
    output logic [15:0]       TXN_CNT
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam int         DEPTH     = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_cnt;
    logic [3:0]        w_nextCnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wrN;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_ram [0:DEPTH-1];
    logic              r_ackN;
    logic [DATA_W-1:0] r_dout;
    logic [15:0]       r_txnCnt;

    logic              w_capture;
    logic              w_enterAck;
    logic [ADDR_W-1:0] w_memAddr;
    logic              w_memWrN;
    logic [DATA_W-1:0] w_memDin;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (!AS_N) begin
                    if (WAIT_STATES == 0) begin
                        w_nextState = S_ACK;
                    end else begin
                        w_nextState = S_COUNT;
                        w_nextCnt   = WAIT_INIT;
                    end
                end
            end
            // A strobe dropped mid-wait aborts the transfer with no side effects.
            S_COUNT: begin
                if (AS_N) begin
                    w_nextState = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_nextState = S_ACK;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                w_nextState = S_RELEASE;
            end
            S_RELEASE: begin
                if (AS_N) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_capture  = (r_state == S_IDLE) && !AS_N;
    assign w_enterAck = (w_nextState == S_ACK) && (r_state != S_ACK);

    // With zero wait states the access happens on the capture edge itself,
    // so the live bus values are used instead of the not-yet-latched copies.
    assign w_memAddr = w_capture ? ADDR : r_addr;
    assign w_memWrN  = w_capture ? WR_N : r_wrN;
    assign w_memDin  = w_capture ? DIN  : r_din;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_ackN   <= 1'b1;
            r_dout   <= '0;
            r_txnCnt <= 16'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_ackN  <= (w_nextState != S_ACK);
            if (w_enterAck) begin
                r_txnCnt <= r_txnCnt + 16'd1;
                if (w_memWrN) begin
                    r_dout <= r_ram[w_memAddr];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && w_capture) begin
            r_addr <= ADDR;
            r_wrN  <= WR_N;
            r_din  <= DIN;
        end
    end

    // RAM contents survive reset; only the write itself is suppressed.
    always_ff @(posedge CLK) begin
        if (!RESET && w_enterAck && !w_memWrN) begin
            r_ram[w_memAddr] <= w_memDin;
        end
    end

    assign ACK_N   = r_ackN;
    assign DOUT    = r_dout;
    assign STATE   = r_state;
    assign TXN_CNT = r_txnCnt;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: a master-side driver pushes expected responses,
// a monitor pops them on every acknowledge; a second zero-wait-state instance is checked directly.
module tb_mem_bus_responder;

    localparam int WS = 2;

    typedef struct {
        logic [31:0] dout;
        logic [15:0] txn;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET, AS_N, WR_N;
    logic [7:0]  ADDR;
    logic [31:0] DIN, DOUT;
    logic        ACK_N;
    logic [1:0]  STATE;
    logic [15:0] TXN_CNT;

    logic        bReset, bAsN, bWrN;
    logic [7:0]  bAddr;
    logic [31:0] bDin, bDout;
    logic        bAckN;
    logic [1:0]  bState;
    logic [15:0] bTxn;

    int          nVectors = 0;
    int          nMiscompares = 0;
    exp_t        expQ[$];
    exp_t        monE;
    bit          prevAck = 1'b0;
    bit          bDone = 1'b0;
    logic [31:0] modelRam [256];
    bit          modelValid [256];
    logic [15:0] modelTxn = 16'd0;
    logic [31:0] modelLastRead = 32'd0;

    always #5 CLK = ~CLK;

    mem_bus_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(WS)) dut (
        .CLK(CLK), .RESET(RESET), .AS_N(AS_N), .WR_N(WR_N), .ADDR(ADDR), .DIN(DIN),
        .ACK_N(ACK_N), .DOUT(DOUT), .STATE(STATE), .TXN_CNT(TXN_CNT)
    );

    mem_bus_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) dutZero (
        .CLK(CLK), .RESET(bReset), .AS_N(bAsN), .WR_N(bWrN), .ADDR(bAddr), .DIN(bDin),
        .ACK_N(bAckN), .DOUT(bDout), .STATE(bState), .TXN_CNT(bTxn)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reset held two cycles with a write strobed the whole time; the write must not land.
    task automatic applyReset();
        RESET = 1'b1;
        AS_N  = 1'b0;
        WR_N  = 1'b0;
        ADDR  = 8'h30;
        DIN   = 32'h0BAD0BAD;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        AS_N  = 1'b1;
        modelTxn      = 16'd0;
        modelLastRead = 32'd0;
        checkOutput("resetAck", ACK_N, 1);
        checkOutput("resetDout", DOUT, 0);
        checkOutput("resetState", STATE, 0);
        checkOutput("resetTxn", TXN_CNT, 0);
    endtask

    // One transfer from IDLE; hold = extra cycles AS_N stays low after the acknowledge.
    task automatic applyStimulus(input bit isWrite, input logic [7:0] addr, input logic [31:0] data, input int hold);
        int   n;
        exp_t e;
        AS_N = 1'b0;
        WR_N = !isWrite;
        ADDR = addr;
        DIN  = data;
        modelTxn++;
        if (isWrite) begin
            modelRam[addr]   = data;
            modelValid[addr] = 1'b1;
        end else begin
            modelLastRead = modelRam[addr];
        end
        e.dout = modelLastRead;
        e.txn  = modelTxn;
        expQ.push_back(e);
        @(posedge CLK);
        #1;
        n    = 1;
        WR_N = 1'($urandom);
        ADDR = 8'($urandom);
        DIN  = $urandom;
        while (ACK_N !== 1'b0 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput("ackLatency", n, WS + 1);
        repeat (hold) begin
            @(posedge CLK);
            #1;
            checkOutput("holdState", STATE, 3);
            checkOutput("holdAck", ACK_N, 1);
        end
        AS_N = 1'b1;
        if (hold == 0) @(posedge CLK);
        @(posedge CLK);
        #1;
        checkOutput("releaseIdle", STATE, 0);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (ACK_N === 1'b0) begin
                checkOutput("ackState", STATE, 2);
                checkOutput("ackPulseWidth", prevAck, 0);
                if (expQ.size() == 0) begin
                    nVectors++;
                    nMiscompares++;
                    $display("[TB] FAIL unexpectedAck: got ACK_N=0 with TXN_CNT=%h, required no acknowledge", TXN_CNT);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("dout", DOUT, monE.dout);
                    checkOutput("txnCnt", TXN_CNT, monE.txn);
                end
            end
            prevAck = (ACK_N === 1'b0);
        end
    end

    initial begin
        bReset = 1'b1;
        bAsN   = 1'b1;
        bWrN   = 1'b1;
        bAddr  = 8'h00;
        bDin   = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        bReset = 1'b0;
        checkOutput("zeroResetDout", bDout, 0);
        bAsN  = 1'b0;
        bWrN  = 1'b0;
        bAddr = 8'h05;
        bDin  = 32'h12345678;
        @(posedge CLK);
        #1;
        checkOutput("zeroWriteAck", bAckN, 0);
        checkOutput("zeroWriteTxn", bTxn, 1);
        checkOutput("zeroWriteDout", bDout, 0);
        bAsN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("zeroIdle", bState, 0);
        bAsN  = 1'b0;
        bWrN  = 1'b1;
        bAddr = 8'h05;
        bDin  = 32'h0;
        @(posedge CLK);
        #1;
        checkOutput("zeroReadAck", bAckN, 0);
        checkOutput("zeroReadDout", bDout, 32'h12345678);
        checkOutput("zeroReadTxn", bTxn, 2);
        bAsN = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("zeroAckPulse", bAckN, 1);
        checkOutput("zeroDoutHold", bDout, 32'h12345678);
        bDone = 1'b1;
    end

    initial begin
        int          t;
        logic [7:0]  a;
        bit          w;
        foreach (modelValid[i]) modelValid[i] = 1'b0;
        applyReset();
        applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, 0);
        applyStimulus(1'b0, 8'h10, 32'h0, 0);
        applyStimulus(1'b1, 8'h30, 32'h11111111, 1);
        applyReset();
        applyStimulus(1'b0, 8'h30, 32'h0, 0);

        applyStimulus(1'b1, 8'h20, 32'h00005555, 0);
        AS_N = 1'b0;
        WR_N = 1'b0;
        ADDR = 8'h20;
        DIN  = 32'h0000AAAA;
        @(posedge CLK);
        #1;
        checkOutput("abortCountState", STATE, 1);
        AS_N = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("abortState", STATE, 0);
        checkOutput("abortAck", ACK_N, 1);
        checkOutput("abortTxn", TXN_CNT, modelTxn);
        repeat (3) @(posedge CLK);
        #1;
        applyStimulus(1'b0, 8'h20, 32'h0, 3);

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            w = ($urandom_range(0, 1) == 1) || !modelValid[a];
            applyStimulus(w, a, $urandom, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end

        t = 0;
        while ((expQ.size() != 0 || !bDone) && t < 100) begin
            @(posedge CLK);
            t++;
        end
        #1;
        checkOutput("queueDrained", expQ.size(), 0);
        checkOutput("zeroInstanceDone", bDone, 1);
        checkOutput("finalTxn", TXN_CNT, modelTxn);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
